// File: rtl/lock_ctrl_param.sv
// N-digit code lock: set/verify an entered code with a timed alarm lockout after MAX_FAIL consecutive failures.
// Latency: every state/output change lands on the clk edge after the qualifying input pulse; all outputs registered.
// Backpressure: none, inputs are single-cycle pulses; optional LOCK_BACKSPACE_EN makes key 0xE delete the newest digit.
module lock_ctrl_param #(
    parameter int DIGITS         = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 100000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  encrypt,
    input  logic                  decrypt,
    input  logic                  ascertain,
    input  logic                  keyboard_en,
    input  logic [3:0]            keyboard_num,
    output logic                  locked,
    output logic                  unlocked,
    output logic                  alarm,
    output logic [2:0]            fail_times,
    output logic [4*DIGITS-1:0]   entered_password,
    output logic [3:0]            entry_count
);

    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = $clog2(LOCKOUT_CYCLES);

    localparam logic [3:0]       DIGITS_C   = 4'(DIGITS);
    localparam logic [2:0]       MAX_FAIL_C = 3'(MAX_FAIL);
    localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCKOUT_CYCLES - 1);

    localparam logic [2:0] ST_OPEN   = 3'd0;
    localparam logic [2:0] ST_SET    = 3'd1;
    localparam logic [2:0] ST_LOCKED = 3'd2;
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] ST_ALARM  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [W-1:0]     entry_q, entry_d;
    logic [W-1:0]     code_q, code_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       fail_q, fail_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             unlocked_q, unlocked_d;
    logic             alarm_q, alarm_d;

    logic set_side;
    logic verify_side;
    logic entering;
    logic restart;
    logic full;
    logic is_digit;

    always_comb begin
        state_d    = state_q;
        entry_d    = entry_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        fail_d     = fail_q;
        lock_cnt_d = lock_cnt_q;

        set_side    = (state_q == ST_OPEN)   || (state_q == ST_SET);
        verify_side = (state_q == ST_LOCKED) || (state_q == ST_VERIFY);
        entering    = (state_q == ST_SET)    || (state_q == ST_VERIFY);
        // A restart pulse only counts in states where it has a meaning.
        restart     = (set_side && encrypt) || (verify_side && decrypt);
        full        = (cnt_q == DIGITS_C);
        is_digit    = (keyboard_num <= 4'd9);

        if (state_q == ST_ALARM) begin
            if (lock_cnt_q == '0) begin
                state_d = ST_LOCKED;
                fail_d  = 3'd0;
            end else begin
                lock_cnt_d = lock_cnt_q - 1'b1;
            end
        end else if (restart) begin
            entry_d = '0;
            cnt_d   = 4'd0;
            state_d = set_side ? ST_SET : ST_VERIFY;
        end else if (entering && ascertain) begin
            if (full) begin
                entry_d = '0;
                cnt_d   = 4'd0;
                if (state_q == ST_SET) begin
                    code_d  = entry_q;
                    state_d = ST_LOCKED;
                end else if (entry_q == code_q) begin
                    fail_d  = 3'd0;
                    state_d = ST_OPEN;
                end else if (fail_q + 3'd1 == MAX_FAIL_C) begin
                    fail_d     = MAX_FAIL_C;
                    lock_cnt_d = LOCK_LOAD;
                    state_d    = ST_ALARM;
                end else begin
                    fail_d  = fail_q + 3'd1;
                    state_d = ST_LOCKED;
                end
            end
        end else if (entering && keyboard_en) begin
            if (is_digit && !full) begin
                entry_d = {entry_q[W-5:0], keyboard_num};
                cnt_d   = cnt_q + 4'd1;
            end
`ifdef LOCK_BACKSPACE_EN
            else if (keyboard_num == 4'hE && cnt_q != 4'd0) begin
                entry_d = {4'h0, entry_q[W-1:4]};
                cnt_d   = cnt_q - 4'd1;
            end
`endif
        end

        // Status flags follow the next state so they stay aligned with it.
        locked_d   = (state_d == ST_LOCKED) || (state_d == ST_VERIFY) || (state_d == ST_ALARM);
        unlocked_d = (state_d == ST_OPEN)   || (state_d == ST_SET);
        alarm_d    = (state_d == ST_ALARM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OPEN;
            entry_q    <= '0;
            code_q     <= '0;
            cnt_q      <= 4'd0;
            fail_q     <= 3'd0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
            unlocked_q <= 1'b1;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            entry_q    <= entry_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            unlocked_q <= unlocked_d;
            alarm_q    <= alarm_d;
        end
    end

    assign locked           = locked_q;
    assign unlocked         = unlocked_q;
    assign alarm            = alarm_q;
    assign fail_times       = fail_q;
    assign entered_password = entry_q;
    assign entry_count      = cnt_q;

endmodule

// File: doc/lock_ctrl_param.md
Name: lock_ctrl_param

Overview:
- Parametrised successor to the 3-digit password controller of the cypher lock.
- Stores and verifies an N-digit code entered from the debounced 4x4 keyboard decoder.
- Counts failed attempts and enters a timed alarm lockout after MAX_FAIL consecutive failures.
- Sits between the keyboard block and the 7-segment display block; feeds the entered digits and the entry count to the display.

Parameters:
- DIGITS, 4, code length in decimal digits (2..8).
- MAX_FAIL, 3, consecutive failures that trigger the alarm (1..7).
- LOCKOUT_CYCLES, 100000000, clk cycles spent in the alarm state (at least 2).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- encrypt  in  1  one-cycle pulse: start setting a new code
- decrypt  in  1  one-cycle pulse: start an unlock attempt
- ascertain  in  1  one-cycle pulse: confirm entry
- keyboard_en  in  1  one-cycle pulse: keyboard_num is valid
- keyboard_num  in  4  key value 0x0..0xF
- locked  out  1  high in LOCKED, VERIFY and ALARM
- unlocked  out  1  high in OPEN and SET
- alarm  out  1  high in ALARM
- fail_times  out  3  consecutive failed attempts
- entered_password  out  4*DIGITS  BCD digits entered so far; newest digit in bits [3:0]
- entry_count  out  4  number of digits entered, 0..DIGITS

Behaviour:
- All outputs are registered.
- Reset values:
  - state=OPEN, unlocked=1, locked=0, alarm=0
  - fail_times=0, entered_password=0, entry_count=0
  - stored code=0, lockout counter=0
- States: OPEN, SET, LOCKED, VERIFY, ALARM.
- OPEN:
  - encrypt -> SET; clear the entry.
  - decrypt and ascertain are ignored.
- SET and VERIFY digit entry:
  - keyboard_en with keyboard_num in 0..9 and entry_count<DIGITS: shift entered_password left 4 bits, insert the digit at [3:0], entry_count+1.
  - Digits arriving when entry_count==DIGITS are dropped.
  - Keys 0xA..0xF are ignored (see Optional Feature).
- SET:
  - ascertain with entry_count==DIGITS: store entered_password as the code -> LOCKED; clear the entry.
  - ascertain with entry_count<DIGITS is ignored; the block stays in SET and keeps the entry.
  - encrypt restarts the entry (clears it).
- LOCKED:
  - decrypt -> VERIFY; clear the entry.
  - encrypt and ascertain are ignored.
- VERIFY, ascertain with entry_count==DIGITS:
  - Match: -> OPEN, fail_times=0.
  - Mismatch with fail_times+1<MAX_FAIL: fail_times+1 -> LOCKED.
  - Mismatch with fail_times+1==MAX_FAIL: fail_times=MAX_FAIL -> ALARM, lockout counter loaded with LOCKOUT_CYCLES-1.
  - Clear the entry on every outcome.
- VERIFY, other inputs:
  - ascertain with a short entry is ignored.
  - decrypt restarts the entry.
- ALARM:
  - All inputs except rst are ignored.
  - The counter decrements each cycle.
  - At 0: -> LOCKED, fail_times=0, alarm deasserts.
  - The block is in ALARM for exactly LOCKOUT_CYCLES cycles.
- Latency: every state and output change is visible on the clk edge after the qualifying input cycle.
- Simultaneous pulses in one cycle, priority from highest: encrypt/decrypt restart, then ascertain, then keyboard_en. Lower-priority pulses in that cycle are dropped.
- rst mid-entry or mid-lockout returns to the reset values immediately and asynchronously. The stored code is cleared, so the lock reopens.
- Comparison covers all 4*DIGITS bits. Unused upper entry bits are always 0.

Optional Feature:
- Macro: LOCK_BACKSPACE_EN.
- Defined: in SET/VERIFY, keyboard_num==0xE with entry_count>0 shifts entered_password right 4 bits (zero fill at the top) and decrements entry_count. With entry_count==0 it is ignored.
- Not defined: 0xE is ignored like the other non-decimal keys.

Test Plan (DIGITS=4, MAX_FAIL=3, LOCKOUT_CYCLES=16):
- Set code: rst, encrypt, keys 1,2,3,4, ascertain -> locked=1, unlocked=0, entry_count=0. Stored code 0x1234 is confirmed by the next scenario.
- Unlock: decrypt, keys 1,2,3,4, ascertain -> unlocked=1, fail_times=0.
- Overflow and short entry:
  - In SET, keys 1,2,3,4,5 -> entered_password=0x1234, entry_count=4.
  - In SET with 3 digits, ascertain -> still SET.
  - Key 0xA -> no change.
- Lockout: three decrypt/0000/ascertain attempts -> fail_times 1, 2, then 3 with alarm=1. Alarm stays high for exactly 16 cycles, then locked=1, fail_times=0. decrypt during the alarm is ignored.
- Same-cycle pulses:
  - ascertain with keyboard_en in the same cycle -> the digit is dropped.
  - decrypt with ascertain in VERIFY -> entry cleared, still VERIFY.
  - rst during ALARM -> unlocked=1, alarm=0 on the same edge.
- Backspace with LOCK_BACKSPACE_EN defined: keys 1,2,0xE,3 -> entered_password=0x0013, entry_count=2. With the macro undefined, 0xE is ignored -> 0x0123.
